// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and default bit timing.
// Exports rx_state_e and CLKS_PER_BIT_DEF (100 MHz / 115200 baud).
package uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 868;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

endpackage

// File: rtl/uart_receiver_if.sv
// Receiver-side bundle: serial line in, byte/status out.
// master drives rx and observes results; slave is the receiver.
interface uart_receiver_if;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_error;
  logic       busy;

  modport master (
    output rx,
    input  data,
    input  valid,
    input  frame_error,
    input  busy
  );

  modport slave (
    input  rx,
    output data,
    output valid,
    output frame_error,
    output busy
  );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous bit.
// Ports: clk, rst_i (sync, active-high), d_i async in, q_o synced out.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver, mid-bit sampling, frame error + break handling.
// Ports: clk, i_reset, i_rx; o_data, o_valid, o_frame_error, o_busy.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       i_reset,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_error,
  output logic       o_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  logic rx;

  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;

  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .rst_i(i_reset),
    .d_i  (i_rx),
    .q_o  (rx)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rx) begin
          state_d = START;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == FULL) begin
          cnt_d   = '0;
          // LSB arrives first, so shift in from the top
          shift_d = {rx, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == FULL) begin
          cnt_d = '0;
          if (rx) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      BREAK: begin
        if (rx) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign o_data        = data_q;
  assign o_valid       = valid_q;
  assign o_frame_error = ferr_q;
  assign o_busy        = (state_q != IDLE);

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 868, giving clock cycles per serial bit (100 MHz / 115200 baud); legal range 4..65535.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port i_reset, input, 1 bit; reset is synchronous and active-high.
REQ-004 The block SHALL have port i_rx, input, 1 bit: the asynchronous serial line, idle high.
REQ-005 The block SHALL have port o_data, output, 8 bits: the last correctly framed byte.
REQ-006 The block SHALL have port o_valid, output, 1 bit: a one-cycle pulse when o_data is updated.
REQ-007 The block SHALL have port o_frame_error, output, 1 bit: a one-cycle pulse when the stop bit is sampled low.
REQ-008 The block SHALL have port o_busy, output, 1 bit: high whenever the FSM is not IDLE.

Function
REQ-009 The frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1); no parity.
REQ-010 i_rx SHALL pass through a 2-flop synchronizer (both flops reset to 1) before any use; "rx" below means the synchronized value.
REQ-011 FSM states SHALL be IDLE, START, DATA, STOP, BREAK.
REQ-012 IDLE: on rx==0, go to START with the bit counter cleared.
REQ-013 START: after (CLKS_PER_BIT-1)/2 cycles (mid start bit), sample rx; 0 -> DATA with counters cleared; 1 -> IDLE as a glitch, with no output pulse.
REQ-014 DATA: sample rx every CLKS_PER_BIT cycles; the k-th sample (k=0..7) goes to o_data bit k via a shift register; after the 8th sample go to STOP.
REQ-015 STOP: after CLKS_PER_BIT cycles sample rx; 1 -> load the shift register into o_data, pulse o_valid, go to IDLE; 0 -> pulse o_frame_error, leave o_data unchanged, go to BREAK.
REQ-016 BREAK: stay until rx==1, then go to IDLE; no frame is detected while the line is held low.
REQ-017 o_valid and o_frame_error SHALL be mutually exclusive and each high for exactly one cycle per frame.
REQ-018 o_valid SHALL rise (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT + 3 cycles (±1) after the first clk edge at which i_rx is low.
REQ-019 Because IDLE is re-entered at mid stop bit, back-to-back frames with no idle gap SHALL be received without loss.
REQ-020 o_data SHALL hold its value between frames and change only together with o_valid.
REQ-021 The cycle counter width SHALL be $clog2(CLKS_PER_BIT); it SHALL never wrap within a bit period.

Reset
REQ-022 While i_reset is high at a clk edge: FSM=IDLE, counters=0, shift register=0, o_data=8'h00, o_valid=0, o_frame_error=0, o_busy=0, synchronizer flops=1.
REQ-023 Reset mid-frame SHALL abort the frame with no o_valid or o_frame_error pulse; reception restarts on the next falling edge after reset is released.

Structure
REQ-024 Package uart_pkg SHALL hold the receiver state enum typedef and the shared default CLKS_PER_BIT constant; uart_transmitter uses the same constant.
REQ-025 The synchronizer SHALL be sub-module sync_2ff (1-bit, synchronous reset, parameter reset value); all other logic stays in uart_receiver.

Verification (CLKS_PER_BIT=16 unless noted)
REQ-026 Loopback: uart_transmitter sends 8'hA5 into i_rx -> one o_valid pulse with o_data=8'hA5; o_frame_error stays 0; o_busy falls after the pulse.
REQ-027 Glitch: i_rx low for 4 cycles, then high -> no o_valid or o_frame_error; o_busy returns to 0 within 9 cycles.
REQ-028 Bad stop bit: frame 8'h3C with stop=0 and line held low 40 cycles -> one o_frame_error pulse, o_data keeps its previous value, no new frame until i_rx goes high.
REQ-029 Back-to-back: 8'h00 then 8'hFF with no idle gap -> two o_valid pulses, data 8'h00 then 8'hFF, spaced 160 cycles.
REQ-030 Reset mid-frame: assert i_reset during data bit 4 of 8'h55 -> no pulses; all outputs at reset values; a following 8'h81 is received correctly.
REQ-031 Default CLKS_PER_BIT=868: a single 8'h7E frame -> o_valid at the REQ-018 latency ±1 cycle.
